// File: rtl/bias_pkg.sv
// bias_pkg: shared constants, types and address-map helpers for the bias
// store (ROM/RAM) and its write-side loader.
//   calc_layer_offsets() : flat base address of each layer
//   calc_total_biases()  : total number of bias words across all layers
//   calc_max_channels()  : largest per-layer channel count
//   safe_clog2()         : $clog2 clamped to at least 1 bit
//   bias_ld_state_t      : loader FSM state encoding
package bias_pkg;

    // Layer tables are fixed-size so every user can share one array type;
    // entries at and above the active layer count are ignored.
    localparam int MAX_LAYERS = 8;

    typedef int layer_arr_t [MAX_LAYERS];

    localparam int         DEF_NUM_LAYERS     = 4;
    localparam layer_arr_t DEF_LAYER_CHANNELS = '{32'd4, 32'd8, 32'd16, 32'd32,
                                                  32'd0, 32'd0, 32'd0,  32'd0};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } bias_ld_state_t;

    // Width helper that never yields a zero-width vector.
    function automatic int safe_clog2(input int value);
        if (value <= 1) begin
            return 1;
        end else begin
            return $clog2(value);
        end
    endfunction

    // Running sum of channel counts: offset of layer i = sum of layers 0..i-1.
    function automatic layer_arr_t calc_layer_offsets(input layer_arr_t channels,
                                                      input int         num_layers);
        layer_arr_t offsets;
        int         acc;
        acc = 0;
        for (int i = 0; i < MAX_LAYERS; i++) begin
            offsets[i] = acc;
            if (i < num_layers) begin
                acc = acc + channels[i];
            end else begin
                acc = acc;
            end
        end
        return offsets;
    endfunction

    function automatic int calc_total_biases(input layer_arr_t channels,
                                             input int         num_layers);
        int acc;
        acc = 0;
        for (int i = 0; i < MAX_LAYERS; i++) begin
            if (i < num_layers) begin
                acc = acc + channels[i];
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    function automatic int calc_max_channels(input layer_arr_t channels,
                                             input int         num_layers);
        int mx;
        mx = 0;
        for (int i = 0; i < MAX_LAYERS; i++) begin
            if ((i < num_layers) && (channels[i] > mx)) begin
                mx = channels[i];
            end else begin
                mx = mx;
            end
        end
        return mx;
    endfunction

    localparam int TOTAL_BIASES = calc_total_biases(DEF_LAYER_CHANNELS, DEF_NUM_LAYERS);
    localparam int MAX_CHANNELS = calc_max_channels(DEF_LAYER_CHANNELS, DEF_NUM_LAYERS);
    localparam int ADDR_W       = safe_clog2(TOTAL_BIASES);
    localparam int CH_W         = safe_clog2(MAX_CHANNELS);

endpackage

// File: rtl/bias_word_packer.sv
// bias_word_packer: assembles a little-endian byte stream into BIAS_WIDTH words.
//   clk, rst_n  : clock / asynchronous active-low reset
//   clear       : drop any partially assembled word and restart at byte 0
//   byte_acc    : byte_in is consumed this cycle
//   byte_in     : stream byte
//   word_valid  : high in the cycle the final byte of a word is consumed
//   word        : complete word (valid alongside word_valid)
module bias_word_packer
    import bias_pkg::*;
#(
    parameter int BIAS_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  byte_acc,
    input  logic [7:0]            byte_in,
    output logic                  word_valid,
    output logic [BIAS_WIDTH-1:0] word
);

    localparam int BPW  = BIAS_WIDTH / 8;
    localparam int BC_W = safe_clog2(BPW);

    logic [BIAS_WIDTH-1:0] sr_q, sr_d;
    logic [BC_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic                  last_s;

    // Place the incoming byte at its lane; earlier lanes come from the register.
    always_comb begin
        word               = sr_q;
        word[int'(byte_cnt_q) * 8 +: 8] = byte_in;
        last_s             = (byte_cnt_q == BC_W'(BPW - 1));
        word_valid         = byte_acc && last_s;
    end

    // Next-state for lane register and byte counter; clear has priority.
    always_comb begin
        sr_d       = sr_q;
        byte_cnt_d = byte_cnt_q;
        if (clear) begin
            sr_d       = '0;
            byte_cnt_d = '0;
        end else if (byte_acc) begin
            sr_d = word;
            if (last_s) begin
                byte_cnt_d = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + BC_W'(1);
            end
        end else begin
            sr_d       = sr_q;
            byte_cnt_d = byte_cnt_q;
        end
    end

    // Lane register and byte counter flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q       <= '0;
            byte_cnt_q <= '0;
        end else begin
            sr_q       <= sr_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

endmodule

// File: rtl/bias_loader.sv
// bias_loader: loads one layer's biases from a byte stream into the bias store.
//   clk, rst_n   : clock / asynchronous active-low reset
//   start, abort : begin loading layer_sel / cancel an in-progress load
//   layer_sel    : layer to load, sampled when start is accepted
//   s_data, s_valid, s_ready : byte stream (valid/ready)
//   wr_en, wr_addr, wr_data  : bias store write port (registered)
//   busy  : load in progress;  done : load complete pulse;  err : bad layer pulse
module bias_loader
    import bias_pkg::*;
#(
    parameter int         NUM_LAYERS     = DEF_NUM_LAYERS,
    parameter layer_arr_t LAYER_CHANNELS = DEF_LAYER_CHANNELS,
    parameter int         BIAS_WIDTH     = 32,
    localparam int        LAYER_W        = safe_clog2(NUM_LAYERS),
    localparam int        TOTAL_L        = calc_total_biases(LAYER_CHANNELS, NUM_LAYERS),
    localparam int        ADDR_W_L       = safe_clog2(TOTAL_L)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LAYER_W-1:0]    layer_sel,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_W_L-1:0]   wr_addr,
    output logic [BIAS_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam layer_arr_t LAYER_OFFSETS = calc_layer_offsets(LAYER_CHANNELS, NUM_LAYERS);
    localparam int         CH_W_L        = safe_clog2(calc_max_channels(LAYER_CHANNELS, NUM_LAYERS));

    bias_ld_state_t        state_q, state_d;
    logic [LAYER_W-1:0]    layer_q, layer_d;
    logic [CH_W_L-1:0]     ch_cnt_q, ch_cnt_d;
    logic                  s_ready_q, s_ready_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_W_L-1:0]   wr_addr_q, wr_addr_d;
    logic [BIAS_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  layer_ok_s;
    logic                  start_acc_s;
    logic                  byte_acc_s;
    logic                  last_ch_s;
    logic                  word_valid_s;
    logic [BIAS_WIDTH-1:0] word_s;

    // Request decode. abort beats start, and an aborting cycle consumes no byte,
    // so a word completing under abort is never written.
    always_comb begin
        layer_ok_s  = (int'(layer_sel) < NUM_LAYERS);
        start_acc_s = (state_q == IDLE) && start && !abort && layer_ok_s;
        byte_acc_s  = (state_q == LOAD) && s_valid && s_ready_q && !abort;
        last_ch_s   = (int'(ch_cnt_q) == (LAYER_CHANNELS[int'(layer_q)] - 1));
    end

    bias_word_packer #(
        .BIAS_WIDTH (BIAS_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_acc_s || abort),
        .byte_acc   (byte_acc_s),
        .byte_in    (s_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_acc_s) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (word_valid_s && last_ch_s) begin
                    state_d = FINISH;
                end else begin
                    state_d = LOAD;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs and datapath next values (all registered below).
    always_comb begin
        layer_d   = layer_q;
        ch_cnt_d  = ch_cnt_q;
        s_ready_d = (state_d == LOAD);
        wr_en_d   = word_valid_s;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (word_valid_s) begin
            wr_addr_d = ADDR_W_L'(LAYER_OFFSETS[int'(layer_q)] + int'(ch_cnt_q));
            wr_data_d = word_s;
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end

        case (state_q)
            IDLE: begin
                if (start_acc_s) begin
                    layer_d  = layer_sel;
                    ch_cnt_d = '0;
                end else begin
                    layer_d  = layer_q;
                    ch_cnt_d = ch_cnt_q;
                end
                err_d = start && !abort && !layer_ok_s;
            end
            LOAD: begin
                if (abort) begin
                    ch_cnt_d = '0;
                end else if (word_valid_s && !last_ch_s) begin
                    ch_cnt_d = ch_cnt_q + CH_W_L'(1);
                end else begin
                    // The last channel holds its count; it wraps on the way out of FINISH.
                    ch_cnt_d = ch_cnt_q;
                end
            end
            FINISH: begin
                ch_cnt_d = '0;
                done_d   = !abort;
            end
            default: begin
                ch_cnt_d = '0;
            end
        endcase
    end

    // Datapath and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_q   <= '0;
            ch_cnt_q  <= '0;
            s_ready_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            layer_q   <= layer_d;
            ch_cnt_q  <= ch_cnt_d;
            s_ready_q <= s_ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign s_ready = s_ready_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bias_loader.sv
// Testbench for bias_loader: scoreboard of expected (addr, data) writes built
// from the bytes driven, checked against every wr_en cycle of the DUT.
module tb_bias_loader;
    import bias_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start, abort;
    logic [1:0]  layer_sel;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready, wr_en, busy, done, err;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;

    // Second instance: three layers, so layer_sel=3 is out of range.
    logic        start3, abort3;
    logic [1:0]  layer_sel3;
    logic        s_ready3, wr_en3, busy3, done3, err3;
    logic [4:0]  wr_addr3;
    logic [31:0] wr_data3;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr = 0, n_done = 0, n_errp = 0, n_wr3 = 0;

    logic [5:0]  exp_addr [$];
    logic [31:0] exp_data [$];

    int offs  [4] = '{0, 4, 12, 28};

    bias_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .layer_sel(layer_sel),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    bias_loader #(
        .NUM_LAYERS     (3),
        .LAYER_CHANNELS ('{32'd4, 32'd8, 32'd16, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0})
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .layer_sel(layer_sel3),
        .s_data(8'h00), .s_valid(1'b0), .s_ready(s_ready3),
        .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .busy(busy3), .done(done3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every wr_en must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                n_wr++;
                if (exp_addr.size() == 0) begin
                    chk("unexpected_wr", {58'd0, wr_addr}, 64'h3f);
                end else begin
                    chk("wr_addr", {58'd0, wr_addr}, {58'd0, exp_addr.pop_front()});
                    chk("wr_data", {32'd0, wr_data}, {32'd0, exp_data.pop_front()});
                end
            end
            if (done)   n_done++;
            if (err)    n_errp++;
            if (wr_en3) n_wr3++;
        end
    end

    task automatic do_start(input int layer);
        @(negedge clk);
        start = 1'b1;
        layer_sel = 2'(layer);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("ready_after_start", {63'd0, s_ready}, 64'd1);
    endtask

    // Drive up to lim bytes (first, first+1, ...) and push the full words they form.
    // restart_at >= 0 pulses start (layer 0) once when that many bytes were accepted.
    task automatic send(input int layer, input int lim, input int first,
                        input bit toggle, input int restart_at);
        int idx;
        int cyc;
        bit v;
        bit rdy;
        bit restarted;
        int b;
        idx = 0;
        cyc = 0;
        restarted = 1'b0;
        for (int k = 0; k < lim / 4; k++) begin
            b = first + 4 * k;
            exp_addr.push_back(6'(offs[layer] + k));
            exp_data.push_back({8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)});
        end
        while (idx < lim && cyc < 4000) begin
            @(negedge clk);
            v = toggle ? (cyc % 2 == 0) : 1'b1;
            s_valid = v;
            s_data  = 8'(first + idx);
            if (idx == restart_at && !restarted) begin
                start = 1'b1;
                layer_sel = 2'd0;
                restarted = 1'b1;
            end else begin
                start = 1'b0;
            end
            rdy = s_ready;
            @(posedge clk);
            if (v && rdy) idx++;
            cyc++;
        end
        if (idx != lim) chk("send_timeout", 64'(idx), 64'(lim));
    endtask

    // After the last byte of a layer: write in t+1, done in t+2, idle afterwards.
    task automatic finish_checks(input int wr_before, input int exp_writes, input int done_before);
        @(negedge clk);
        s_valid = 1'b0;
        start = 1'b0;
        chk("ready_off_after_last", {63'd0, s_ready}, 64'd0);
        chk("done_not_early", {63'd0, done}, 64'd0);
        @(negedge clk);
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("busy_low_at_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        repeat (3) @(negedge clk);
        chk("write_count", 64'(n_wr - wr_before), 64'(exp_writes));
        chk("done_count", 64'(n_done - done_before), 64'd1);
        chk("sb_empty", 64'(exp_addr.size()), 64'd0);
    endtask

    int wb, db, eb;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; layer_sel = 2'd0;
        s_data = 8'h00; s_valid = 1'b0;
        start3 = 1'b0; abort3 = 1'b0; layer_sel3 = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_wr_en",   {63'd0, wr_en},   64'd0);
        chk("rst_busy",    {63'd0, busy},    64'd0);
        chk("rst_done",    {63'd0, done},    64'd0);
        chk("rst_err",     {63'd0, err},     64'd0);
        chk("rst_wr_addr", {58'd0, wr_addr}, 64'd0);
        chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: layer 1, bytes 0x01..0x20, continuous valid.
        wb = n_wr; db = n_done;
        do_start(1);
        send(1, 32, 1, 1'b0, -1);
        finish_checks(wb, 8, db);

        // 2: same with valid toggling.
        wb = n_wr; db = n_done;
        do_start(1);
        send(1, 32, 1, 1'b1, -1);
        finish_checks(wb, 8, db);

        // 3: layer 3, 128 bytes, a second start mid-load is ignored.
        wb = n_wr; db = n_done; eb = n_errp;
        do_start(3);
        send(3, 128, 1, 1'b0, 40);
        finish_checks(wb, 32, db);
        chk("no_err_on_busy_start", 64'(n_errp - eb), 64'd0);

        // 4: layer 0, abort after 5 bytes.
        wb = n_wr; db = n_done;
        do_start(0);
        send(0, 5, 8'h50, 1'b0, -1);
        @(negedge clk);
        s_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ready_off", {63'd0, s_ready}, 64'd0);
        chk("abort_busy_off",  {63'd0, busy},    64'd0);
        repeat (6) @(negedge clk);
        chk("abort_writes", 64'(n_wr - wb), 64'd1);
        chk("abort_no_done", 64'(n_done - db), 64'd0);
        chk("abort_sb_empty", 64'(exp_addr.size()), 64'd0);

        // 5: reset during layer 2 after 6 bytes, then a clean reload.
        do_start(2);
        send(2, 6, 8'h90, 1'b0, -1);
        @(negedge clk);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("midrst_busy",    {63'd0, busy},    64'd0);
        chk("midrst_wr_en",   {63'd0, wr_en},   64'd0);
        chk("midrst_wr_addr", {58'd0, wr_addr}, 64'd0);
        chk("midrst_wr_data", {32'd0, wr_data}, 64'd0);
        chk("midrst_sb_empty", 64'(exp_addr.size()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wb = n_wr; db = n_done;
        do_start(2);
        send(2, 64, 8'h40, 1'b0, -1);
        finish_checks(wb, 16, db);

        // 6a: three-layer instance rejects layer 3.
        @(negedge clk);
        start3 = 1'b1;
        layer_sel3 = 2'd3;
        @(negedge clk);
        start3 = 1'b0;
        chk("err3_pulse", {63'd0, err3},  64'd1);
        chk("err3_busy",  {63'd0, busy3}, 64'd0);
        @(negedge clk);
        chk("err3_one_cycle", {63'd0, err3}, 64'd0);
        chk("err3_busy_stays", {63'd0, busy3}, 64'd0);
        repeat (3) @(negedge clk);
        chk("err3_no_writes", 64'(n_wr3), 64'd0);

        // 6b: start and abort together in IDLE: nothing starts.
        start = 1'b1;
        abort = 1'b1;
        layer_sel = 2'd1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("startabort_busy",  {63'd0, busy},    64'd0);
        chk("startabort_ready", {63'd0, s_ready}, 64'd0);
        chk("startabort_err",   {63'd0, err},     64'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
